// File: rtl/c_binary_op_accum_pkg.sv
// Shared operator codes and elaboration-time helpers for the framed
// binary-operator accumulator.
package c_binary_op_accum_pkg;

  // Operator codes (c_constants).
  localparam int BINARY_OP_AND  = 0;
  localparam int BINARY_OP_NAND = 1;
  localparam int BINARY_OP_OR   = 2;
  localparam int BINARY_OP_NOR  = 3;
  localparam int BINARY_OP_XOR  = 4;
  localparam int BINARY_OP_XNOR = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Non-inverting operator underlying op (NAND->AND, NOR->OR, XNOR->XOR).
  function automatic int base_op(input int op);
    case (op)
      BINARY_OP_AND, BINARY_OP_NAND: return BINARY_OP_AND;
      BINARY_OP_OR,  BINARY_OP_NOR:  return BINARY_OP_OR;
      default:                       return BINARY_OP_XOR;
    endcase
  endfunction

  // True for the operators whose result is complemented once at the end.
  function automatic logic op_inverted(input int op);
    return (op == BINARY_OP_NAND) || (op == BINARY_OP_NOR) ||
           (op == BINARY_OP_XNOR);
  endfunction

endpackage

// File: rtl/c_binary_op_accum_binop.sv
// Bitwise reduction of num_ports words with a non-inverting base operator
// (AND, OR or XOR). Purely combinational.
module c_binary_op_accum_binop
  import c_binary_op_accum_pkg::*;
#(
  parameter int num_ports = 4,
  parameter int width     = 8,
  parameter int base      = BINARY_OP_XOR
) (
  input  logic [width*num_ports-1:0] data_in,
  output logic [width-1:0]           data_out
);

  // Fold port words left to right; all base ops are commutative so order
  // does not affect the result.
  always_comb begin
    data_out = data_in[0 +: width];
    for (int i = 1; i < num_ports; i++) begin
      case (base)
        BINARY_OP_AND: data_out = data_out & data_in[i*width +: width];
        BINARY_OP_OR:  data_out = data_out | data_in[i*width +: width];
        default:       data_out = data_out ^ data_in[i*width +: width];
      endcase
    end
  end

endmodule

// File: rtl/c_binary_op_accum.sv
// Framed multi-beat binary operator: reduces each beat across ports, folds
// beats of a frame into an accumulator and emits one registered result per
// frame with beat count, saturation flag and protocol-error pulse.
module c_binary_op_accum
  import c_binary_op_accum_pkg::*;
#(
  parameter int num_ports = 4,
  parameter int width     = 8,
  parameter int op        = BINARY_OP_XOR,
  parameter int max_beats = 16,
  localparam int CW       = clog2(max_beats + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic [width*num_ports-1:0] data_in,
  output logic                       out_valid,
  output logic [width-1:0]           data_out,
  output logic [CW-1:0]              out_beats,
  output logic                       out_sat,
  output logic                       error
);

  localparam int            BASE    = base_op(op);
  localparam logic          INV     = op_inverted(op);
  localparam logic [CW-1:0] CNT_MAX = CW'(max_beats);

  state_t             state_q, state_d;
  logic [width-1:0]   acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic               out_valid_q, out_valid_d;
  logic [width-1:0]   data_out_q, data_out_d;
  logic [CW-1:0]      out_beats_q, out_beats_d;
  logic               out_sat_q, out_sat_d;
  logic               error_q, error_d;

  logic [width-1:0]   beat_w;
  logic [width-1:0]   folded_w;

  // Spatial reduction of the current beat across ports.
  c_binary_op_accum_binop #(
    .num_ports (num_ports),
    .width     (width),
    .base      (BASE)
  ) u_spatial (
    .data_in  (data_in),
    .data_out (beat_w)
  );

  // Temporal fold of the current beat into the accumulator.
  c_binary_op_accum_binop #(
    .num_ports (2),
    .width     (width),
    .base      (BASE)
  ) u_temporal (
    .data_in  ({beat_w, acc_q}),
    .data_out (folded_w)
  );

  // Next-state logic: flush dominates, then valid beats; bubbles hold state.
  always_comb begin
    logic             restart;
    logic [width-1:0] fold;
    logic [CW-1:0]    cnt_new;
    logic             sat_new;

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_valid_d = 1'b0;
    data_out_d  = data_out_q;
    out_beats_d = out_beats_q;
    out_sat_d   = out_sat_q;
    error_d     = 1'b0;
    restart     = 1'b0;
    fold        = '0;
    cnt_new     = '0;
    sat_new     = 1'b0;

    if (flush) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else if (in_valid) begin
      // A beat in IDLE always opens a frame; a first flag mid-frame restarts.
      restart = (state_q == ST_IDLE) || in_first;
      error_d = (state_q == ST_IDLE) ? ~in_first : in_first;

      if (restart) begin
        fold    = beat_w;
        cnt_new = CW'(1);
        sat_new = 1'b0;
      end else begin
        fold = folded_w;
        if (cnt_q == CNT_MAX) begin
          cnt_new = cnt_q;
          sat_new = 1'b1;
        end else begin
          cnt_new = cnt_q + CW'(1);
          sat_new = sat_q;
        end
      end

      if (in_last) begin
        out_valid_d = 1'b1;
        data_out_d  = fold ^ {width{INV}};
        out_beats_d = cnt_new;
        out_sat_d   = sat_new;
        state_d     = ST_IDLE;
        acc_d       = '0;
        cnt_d       = '0;
        sat_d       = 1'b0;
      end else begin
        state_d = ST_ACCUM;
        acc_d   = fold;
        cnt_d   = cnt_new;
        sat_d   = sat_new;
      end
    end
  end

  // State, accumulator and registered outputs with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      out_beats_q <= '0;
      out_sat_q   <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      out_beats_q <= out_beats_d;
      out_sat_q   <= out_sat_d;
      error_q     <= error_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign out_beats = out_beats_q;
  assign out_sat   = out_sat_q;
  assign error     = error_q;

endmodule

// File: tb/tb_c_binary_op_accum.sv
// Directed bench: four instances (XOR, NAND, NOR, OR with max_beats=4) share
// one stimulus stream; each check looks at the instance it concerns.
module tb_c_binary_op_accum;
  import c_binary_op_accum_pkg::*;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_first;
  logic        in_last;
  logic [31:0] data_in;

  logic       x_valid, n_valid, r_valid, o_valid;
  logic [7:0] x_data, n_data, r_data, o_data;
  logic [4:0] x_beats, n_beats, r_beats;
  logic [2:0] o_beats;
  logic       x_sat, n_sat, r_sat, o_sat;
  logic       x_err, n_err, r_err, o_err;

  int n_checks = 0;
  int n_errors = 0;

  c_binary_op_accum #(.num_ports(4), .width(8), .op(BINARY_OP_XOR), .max_beats(16)) u_xor (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .data_in(data_in), .out_valid(x_valid), .data_out(x_data),
    .out_beats(x_beats), .out_sat(x_sat), .error(x_err));

  c_binary_op_accum #(.num_ports(4), .width(8), .op(BINARY_OP_NAND), .max_beats(16)) u_nand (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .data_in(data_in), .out_valid(n_valid), .data_out(n_data),
    .out_beats(n_beats), .out_sat(n_sat), .error(n_err));

  c_binary_op_accum #(.num_ports(4), .width(8), .op(BINARY_OP_NOR), .max_beats(16)) u_nor (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .data_in(data_in), .out_valid(r_valid), .data_out(r_data),
    .out_beats(r_beats), .out_sat(r_sat), .error(r_err));

  c_binary_op_accum #(.num_ports(4), .width(8), .op(BINARY_OP_OR), .max_beats(4)) u_or (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .data_in(data_in), .out_valid(o_valid), .data_out(o_data),
    .out_beats(o_beats), .out_sat(o_sat), .error(o_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  exp_xor;
    logic [7:0]  exp_nand;
    logic [7:0]  exp_nor;
    logic [7:0]  exp_or;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  // Apply inputs at a falling edge and return at the next falling edge,
  // after exactly one rising edge has consumed them.
  task automatic beat(input logic v, input logic f, input logic l, input logic fl,
                      input logic [31:0] d);
    in_valid = v;
    in_first = f;
    in_last  = l;
    flush    = fl;
    data_in  = d;
    @(negedge clk);
  endtask

  task automatic idle();
    beat(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    // Port 0 is the least significant byte.
    vecs[0] = '{32'h08040201, 8'h0F, 8'hFF, 8'hF0, 8'h0F};
    vecs[1] = '{32'hFFFFFFFF, 8'h00, 8'h00, 8'h00, 8'hFF};
    vecs[2] = '{32'h00000000, 8'h00, 8'hFF, 8'hFF, 8'h00};
    vecs[3] = '{32'hFF0F3CF0, 8'h3C, 8'hFF, 8'h00, 8'hFF};
    vecs[4] = '{32'h5555AAAA, 8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[5] = '{32'hFFE7C381, 8'h5A, 8'h7E, 8'h00, 8'hFF};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    data_in = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_valid", {28'h0, x_valid, n_valid, r_valid, o_valid}, 32'h0);
    chk("reset_data", {x_data, n_data, r_data, o_data}, 32'h0);
    chk("reset_beats_sat_err", {x_beats, n_beats, r_beats, o_beats, x_sat, n_sat, r_sat, o_sat,
                                x_err, n_err, r_err, o_err}, 32'h0);
    reset = 1'b0;
    idle();

    // Single-beat frames on all four operators.
    for (int i = 0; i < 6; i++) begin
      beat(1'b1, 1'b1, 1'b1, 1'b0, vecs[i].data);
      chk($sformatf("v%0d_valid", i), {28'h0, x_valid, n_valid, r_valid, o_valid}, 32'hF);
      chk($sformatf("v%0d_xor", i), {24'h0, x_data}, {24'h0, vecs[i].exp_xor});
      chk($sformatf("v%0d_nand", i), {24'h0, n_data}, {24'h0, vecs[i].exp_nand});
      chk($sformatf("v%0d_nor", i), {24'h0, r_data}, {24'h0, vecs[i].exp_nor});
      chk($sformatf("v%0d_or", i), {24'h0, o_data}, {24'h0, vecs[i].exp_or});
      chk($sformatf("v%0d_beats", i), {14'h0, x_beats, n_beats, r_beats, o_beats}, {14'h0, 5'd1, 5'd1, 5'd1, 3'd1});
      chk($sformatf("v%0d_sat_err", i), {24'h0, x_sat, n_sat, r_sat, o_sat, x_err, n_err, r_err, o_err}, 32'h0);
    end
    idle();
    chk("strobe_one_cycle", {31'h0, x_valid}, 32'h0);
    chk("data_hold", {24'h0, x_data}, 32'h5A);

    // XOR 3 beats with a bubble: 0x0F ^ 0xF0 ^ 0x3C = 0xC3.
    beat(1'b1, 1'b1, 1'b0, 1'b0, 32'h08040201);
    chk("x3_b1_novalid", {31'h0, x_valid}, 32'h0);
    beat(1'b1, 1'b0, 1'b0, 1'b0, 32'h80402010);
    chk("x3_b2_novalid", {31'h0, x_valid}, 32'h0);
    idle();
    chk("x3_bubble_novalid", {31'h0, x_valid}, 32'h0);
    beat(1'b1, 1'b0, 1'b1, 1'b0, 32'hFF0F3CF0);
    chk("x3_valid", {31'h0, x_valid}, 32'h1);
    chk("x3_data", {24'h0, x_data}, 32'hC3);
    chk("x3_beats", {27'h0, x_beats}, 32'd3);
    chk("x3_err", {31'h0, x_err}, 32'h0);
    idle();
    chk("x3_after", {31'h0, x_valid}, 32'h0);

    // NAND 2 beats: AND(FF.., FE..) = FE -> 01.
    beat(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF);
    beat(1'b1, 1'b0, 1'b1, 1'b0, 32'hFEFEFEFE);
    chk("nand2_valid", {31'h0, n_valid}, 32'h1);
    chk("nand2_data", {24'h0, n_data}, 32'h01);
    chk("nand2_beats", {27'h0, n_beats}, 32'd2);

    // NOR 2 beats of zeros -> FF.
    beat(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    beat(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("nor2_valid", {31'h0, r_valid}, 32'h1);
    chk("nor2_data", {24'h0, r_data}, 32'hFF);
    chk("nor2_beats", {27'h0, r_beats}, 32'd2);

    // 6-beat frame: OR instance saturates at 4; XOR instance counts 6.
    for (int k = 0; k < 6; k++) begin
      beat(1'b1, (k == 0), (k == 5), 1'b0, 32'h1 << k);
      if (k < 5) chk($sformatf("sat_b%0d_novalid", k), {31'h0, o_valid}, 32'h0);
    end
    chk("sat_valid", {31'h0, o_valid}, 32'h1);
    chk("sat_data", {24'h0, o_data}, 32'h3F);
    chk("sat_beats", {29'h0, o_beats}, 32'd4);
    chk("sat_flag", {31'h0, o_sat}, 32'h1);
    chk("nosat_xor_beats", {26'h0, x_sat, x_beats}, 32'd6);
    beat(1'b1, 1'b1, 1'b1, 1'b0, 32'h000000C0);
    chk("sat_next_flag", {31'h0, o_sat}, 32'h0);
    chk("sat_next_beats", {29'h0, o_beats}, 32'd1);
    chk("sat_next_data", {24'h0, o_data}, 32'hC0);

    // Beat without first in IDLE: error pulse, frame proceeds.
    idle();
    beat(1'b1, 1'b0, 1'b0, 1'b0, 32'h08040201);
    chk("nofirst_err", {31'h0, x_err}, 32'h1);
    chk("nofirst_novalid", {31'h0, x_valid}, 32'h0);
    beat(1'b1, 1'b0, 1'b1, 1'b0, 32'h80402010);
    chk("nofirst_err_clear", {31'h0, x_err}, 32'h0);
    chk("nofirst_valid", {31'h0, x_valid}, 32'h1);
    chk("nofirst_data", {24'h0, x_data}, 32'hFF);
    chk("nofirst_beats", {27'h0, x_beats}, 32'd2);

    // First during ACCUM: restart, count from restart beat.
    beat(1'b1, 1'b1, 1'b0, 1'b0, 32'h11111111);
    beat(1'b1, 1'b0, 1'b0, 1'b0, 32'h22222222);
    chk("refirst_noerr", {31'h0, x_err}, 32'h0);
    beat(1'b1, 1'b1, 1'b0, 1'b0, 32'h08040201);
    chk("refirst_err", {31'h0, x_err}, 32'h1);
    chk("refirst_novalid", {31'h0, x_valid}, 32'h0);
    beat(1'b1, 1'b0, 1'b1, 1'b0, 32'h000000AA);
    chk("refirst_valid", {31'h0, x_valid}, 32'h1);
    chk("refirst_data", {24'h0, x_data}, 32'hA5);
    chk("refirst_beats", {27'h0, x_beats}, 32'd2);

    // Flush with beat 2, then a fresh single-beat frame.
    beat(1'b1, 1'b1, 1'b0, 1'b0, 32'h80402010);
    chk("flush_b1_novalid", {31'h0, x_valid}, 32'h0);
    beat(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000FFFF);
    chk("flush_novalid_noerr", {30'h0, x_valid, x_err}, 32'h0);
    beat(1'b1, 1'b1, 1'b1, 1'b0, 32'h000000AA);
    chk("flush_fresh_valid", {30'h0, x_valid, x_err}, 32'h2);
    chk("flush_fresh_data", {24'h0, x_data}, 32'hAA);
    chk("flush_fresh_beats", {27'h0, x_beats}, 32'd1);
    idle();
    chk("flush_single_strobe", {31'h0, x_valid}, 32'h0);

    // Asynchronous reset between edges mid-frame.
    beat(1'b1, 1'b1, 1'b0, 1'b0, 32'h08040201);
    #2 reset = 1'b1;
    #1;
    chk("areset_data", {24'h0, x_data}, 32'h0);
    chk("areset_beats", {27'h0, x_beats}, 32'h0);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; data_in = 32'h0;
    #1 reset = 1'b0;
    @(negedge clk);
    chk("areset_novalid1", {31'h0, x_valid}, 32'h0);
    idle();
    chk("areset_novalid2", {23'h0, x_valid, x_data}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
